// File: rtl/quantization_unit_if.sv
// Stream bus for quantization_unit: input sample handshake and output result handshake.
interface quantization_unit_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned OUT_WIDTH  = 8
);
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         valid_in;
    logic                         ready_in;
    logic signed [OUT_WIDTH-1:0]  data_out;
    logic                         valid_out;
    logic                         ready_out;

    modport slave (
        input  data_in, valid_in, ready_out,
        output ready_in, data_out, valid_out
    );

    modport master (
        output data_in, valid_in, ready_out,
        input  ready_in, data_out, valid_out
    );
endinterface

// File: rtl/quantization_unit.sv
// 3-stage requantizer: q = sat(round((x * scale) >>> shift) + zero_point).
// Optional saturation event counter enabled by defining QUANT_SAT_CNT_EN.
module quantization_unit #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH   = 8,
    parameter int unsigned SCALE_WIDTH = 16,
    parameter int unsigned SHIFT_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef QUANT_SAT_CNT_EN
    output logic [15:0]                 sat_count,
    input  logic                        sat_clear,
`endif
    input  logic [SCALE_WIDTH-1:0]      scale,
    input  logic [SHIFT_WIDTH-1:0]      shift,
    input  logic signed [OUT_WIDTH-1:0] zero_point,
    quantization_unit_if.slave          bus
);

    localparam int unsigned PROD_W = DATA_WIDTH + SCALE_WIDTH + 1;
    // One spare bit so the rounding bias can never overflow the product.
    localparam int unsigned SUM_W  = PROD_W + 1;
    localparam int unsigned ZP_W   = SUM_W + 1;

    localparam logic signed [ZP_W-1:0] OUT_MAX = ZP_W'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [ZP_W-1:0] OUT_MIN = -OUT_MAX - ZP_W'(1);

    logic                          advance_c;
    logic signed [SUM_W-1:0]       bias_c;
    logic signed [ZP_W-1:0]        sum_c;
    logic                          sat_hi_c;
    logic                          sat_lo_c;

    logic                          s1_valid_q, s1_valid_d;
    logic signed [PROD_W-1:0]      s1_prod_q,  s1_prod_d;
    logic [SHIFT_WIDTH-1:0]        s1_shift_q, s1_shift_d;
    logic signed [OUT_WIDTH-1:0]   s1_zp_q,    s1_zp_d;

    logic                          s2_valid_q, s2_valid_d;
    logic signed [SUM_W-1:0]       s2_round_q, s2_round_d;
    logic signed [OUT_WIDTH-1:0]   s2_zp_q,    s2_zp_d;

    logic                          valid_out_q, valid_out_d;
    logic signed [OUT_WIDTH-1:0]   data_out_q,  data_out_d;

    assign advance_c     = !valid_out_q || bus.ready_out;
    assign bus.ready_in  = advance_c;
    assign bus.valid_out = valid_out_q;
    assign bus.data_out  = data_out_q;

    // Next-state for all three stages; everything holds unless the pipe advances.
    always_comb begin
        bias_c      = '0;
        s1_valid_d  = s1_valid_q;
        s1_prod_d   = s1_prod_q;
        s1_shift_d  = s1_shift_q;
        s1_zp_d     = s1_zp_q;
        s2_valid_d  = s2_valid_q;
        s2_round_d  = s2_round_q;
        s2_zp_d     = s2_zp_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;

        if (s1_shift_q != '0) begin
            bias_c = SUM_W'(1) <<< (s1_shift_q - SHIFT_WIDTH'(1));
        end
        sum_c    = ZP_W'(s2_round_q) + ZP_W'(s2_zp_q);
        sat_hi_c = sum_c > OUT_MAX;
        sat_lo_c = sum_c < OUT_MIN;

        if (advance_c) begin
            s1_valid_d  = bus.valid_in;
            s1_prod_d   = PROD_W'(bus.data_in) * PROD_W'($signed({1'b0, scale}));
            s1_shift_d  = shift;
            s1_zp_d     = zero_point;

            s2_valid_d  = s1_valid_q;
            s2_round_d  = (SUM_W'(s1_prod_q) + bias_c) >>> s1_shift_q;
            s2_zp_d     = s1_zp_q;

            valid_out_d = s2_valid_q;
            if (sat_hi_c) begin
                data_out_d = OUT_WIDTH'(OUT_MAX);
            end else if (sat_lo_c) begin
                data_out_d = OUT_WIDTH'(OUT_MIN);
            end else begin
                data_out_d = OUT_WIDTH'(sum_c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_prod_q   <= '0;
            s1_shift_q  <= '0;
            s1_zp_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_round_q  <= '0;
            s2_zp_q     <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_prod_q   <= s1_prod_d;
            s1_shift_q  <= s1_shift_d;
            s1_zp_q     <= s1_zp_d;
            s2_valid_q  <= s2_valid_d;
            s2_round_q  <= s2_round_d;
            s2_zp_q     <= s2_zp_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
        end
    end

`ifdef QUANT_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    // Counts clamped beats loaded into the output stage; clear wins, no wrap.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clear) begin
            sat_cnt_d = '0;
        end else if (advance_c && s2_valid_q && (sat_hi_c || sat_lo_c)
                     && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_quantization_unit.sv
// Directed self-checking bench for quantization_unit (also covers QUANT_SAT_CNT_EN when defined).
module tb_quantization_unit;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       scale;
    logic [4:0]        shift;
    logic signed [7:0] zero_point;
`ifdef QUANT_SAT_CNT_EN
    logic [15:0]       sat_count;
    logic              sat_clear;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    quantization_unit_if #(.DATA_WIDTH(16), .OUT_WIDTH(8)) bus ();

    quantization_unit #(
        .DATA_WIDTH(16), .OUT_WIDTH(8), .SCALE_WIDTH(16), .SHIFT_WIDTH(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef QUANT_SAT_CNT_EN
        .sat_count  (sat_count),
        .sat_clear  (sat_clear),
`endif
        .scale      (scale),
        .shift      (shift),
        .zero_point (zero_point),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input string tag, input int din, input int sc,
                              input int sh, input int zp, input int exp);
        int cyc;
        bus.data_in   = 16'(din);
        scale         = 16'(sc);
        shift         = 5'(sh);
        zero_point    = 8'(zp);
        bus.valid_in  = 1'b1;
        bus.ready_out = 1'b1;
        #1;
        check({tag, "_rdy"}, int'(bus.ready_in), 1);
        tick();
        // Scramble config after acceptance; the beat must keep its own copy.
        bus.valid_in = 1'b0;
        scale        = 16'hFFFF;
        shift        = 5'd0;
        zero_point   = 8'sd77;
        cyc = 1;
        while (!bus.valid_out && cyc < 10) begin
            tick();
            cyc++;
        end
        check({tag, "_lat"}, cyc, 3);
        check(tag, int'(bus.data_out), exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int cnt;
        logic fire;
        int got_q[$];

        rst           = 1'b1;
        bus.data_in   = '0;
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b0;
        scale         = '0;
        shift         = '0;
        zero_point    = '0;
`ifdef QUANT_SAT_CNT_EN
        sat_clear     = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_valid_out", int'(bus.valid_out), 0);
        check("rst_data_out", int'(bus.data_out), 0);
        check("rst_ready_in", int'(bus.ready_in), 1);
`ifdef QUANT_SAT_CNT_EN
        check("rst_sat_count", int'(sat_count), 0);
`endif

        run_single("basic",    400,   64,    8,  3, 103);
        run_single("rnd_p5",   5,     1,     1,  0, 3);
        run_single("rnd_m5",   -5,    1,     1,  0, -2);
        run_single("rnd_p4",   4,     1,     1,  0, 2);
        run_single("bigsh_neg", -32768, 65535, 31, 0, -1);
        run_single("bigsh_pos", 32767,  65535, 31, 0, 1);
        run_single("sat_hi",   1000,  1,     0,  0, 127);
        run_single("sat_lo",   -1000, 1,     0,  0, -128);

`ifdef QUANT_SAT_CNT_EN
        check("sat_count", int'(sat_count), 2);
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        check("sat_clear", int'(sat_count), 0);
`endif

        // Backpressure: six beats, downstream stalls from cycle 2 to 11.
        scale      = 16'd1;
        shift      = 5'd0;
        zero_point = 8'sd0;
        sent       = 0;
        got_q.delete();
        for (int cyc = 0; cyc < 40; cyc++) begin
            bus.valid_in  = (sent < 6);
            bus.data_in   = 16'(sent + 1);
            bus.ready_out = (cyc < 2) || (cyc >= 12);
            #1;
            if (cyc == 3) begin
                check("bp_first_data", int'(bus.data_out), 1);
            end
            if (cyc == 11) begin
                check("bp_ready_in", int'(bus.ready_in), 0);
                check("bp_hold_valid", int'(bus.valid_out), 1);
                check("bp_hold_data", int'(bus.data_out), 1);
                check("bp_in_flight", sent, 3);
            end
            fire = bus.valid_in && bus.ready_in;
            if (bus.valid_out && bus.ready_out) got_q.push_back(int'(bus.data_out));
            tick();
            if (fire) sent++;
        end
        bus.valid_in = 1'b0;
        check("bp_count", got_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("bp_out%0d", i), (i < got_q.size()) ? got_q[i] : -999, i + 1);
        end

        // Config change between consecutive beats.
        bus.ready_out = 1'b1;
        bus.valid_in  = 1'b1;
        bus.data_in   = 16'sd10;
        zero_point    = 8'sd0;
        tick();
        zero_point    = 8'sd5;
        tick();
        bus.valid_in  = 1'b0;
        zero_point    = 8'sd100;
        got_q.delete();
        for (int c = 0; c < 10; c++) begin
            if (bus.valid_out) got_q.push_back(int'(bus.data_out));
            tick();
        end
        check("cfg_count", got_q.size(), 2);
        check("cfg_first", (got_q.size() > 0) ? got_q[0] : -999, 10);
        check("cfg_second", (got_q.size() > 1) ? got_q[1] : -999, 15);

        // Reset with three beats in flight.
        zero_point   = 8'sd0;
        bus.valid_in = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bus.data_in = 16'(7 + b);
            tick();
        end
        bus.valid_in = 1'b0;
        check("mid_valid_before", int'(bus.valid_out), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_valid_out", int'(bus.valid_out), 0);
        check("mid_data_out", int'(bus.data_out), 0);
        #1;
        check("mid_ready_in", int'(bus.ready_in), 1);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.valid_out) cnt++;
            tick();
        end
        check("mid_no_stale", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
